mvu_out_stage: RTL and testbench



---
 rtl/mvu_pkg.sv | 15 +
 rtl/mvu_out_fifo.sv | 50 +++++
 rtl/mvu_out_stage.sv | 68 ++++++
 tb/tb_mvu_out_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared definitions for the matrix-vector unit: counter-width helper and
// the default packed PE accumulator vector type.
package mvu_pkg;

  localparam int unsigned PE_DEF    = 2;
  localparam int unsigned TDSTI_DEF = 16;

  typedef logic [PE_DEF*TDSTI_DEF-1:0] pe_vec_t;

  // Width of a counter over n states; a 1-state counter still needs one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mvu_out_fifo.sv
// Show-ahead output FIFO for captured PE vectors; exposes its fill count so
// the stage can throttle upstream before the buffer overflows.
module mvu_out_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [W-1:0]               i_dat,
  input  logic                       i_pop,
  output logic [W-1:0]               o_dat,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // NOTE: storage has no reset; only pointers and count define validity, so
  // the array maps onto plain RAM/flops without a reset network.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_dat;
  end

  // NOTE: all state updates are non-blocking so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dat   = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mvu_out_stage.sv
// PE-array output stage: tracks the synapse fold, captures the accumulator
// vector one cycle after each fold's last beat and streams it out.
module mvu_out_stage
  import mvu_pkg::*;
#(
  parameter int unsigned PE    = 2,
  parameter int unsigned TDstI = 16,
  parameter int unsigned SF    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_v,
  output logic                  in_rdy,
  input  logic [PE*TDstI-1:0]   in_acc,
  output logic                  acc_clr,
  output logic                  out_v,
  input  logic                  out_rdy,
  output logic [PE*TDstI-1:0]   out_dat
);

  localparam int unsigned FW = clog2_min1(SF);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [FW-1:0] r_fcnt;
  logic          r_cap_pend;
  logic          w_last;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_occ;

  assign w_last = in_v && (r_fcnt == FW'(SF - 1));

  // The capture always follows the last beat by exactly one cycle, so the
  // pending flag is simply the delayed last-beat strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcnt     <= '0;
      r_cap_pend <= 1'b0;
    end else begin
      r_cap_pend <= w_last;
      if (in_v) r_fcnt <= w_last ? '0 : r_fcnt + 1'b1;
    end
  end

  assign acc_clr = r_cap_pend;

  // Reserve a slot for the pending capture so a push never meets a full FIFO.
  assign w_occ  = {1'b0, w_count} + {{CW{1'b0}}, r_cap_pend};
  assign in_rdy = w_occ < (CW+1)'(DEPTH);

  assign out_v = (w_count != '0);
  assign w_pop = out_v && out_rdy;

  mvu_out_fifo #(
    .DEPTH (DEPTH),
    .W     (PE*TDstI)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_cap_pend),
    .i_dat   (in_acc),
    .i_pop   (w_pop),
    .o_dat   (out_dat),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_mvu_out_stage.sv
// Scoreboard bench for mvu_out_stage: an SF=4 and an SF=1 instance, each with
// a fold model that queues expected vectors and a monitor that checks pops.
module tb_mvu_out_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_v4 = 1'b0, out_rdy4 = 1'b0;
  logic        in_rdy4, acc_clr4, out_v4;
  logic [15:0] in_acc4 = '0, out_dat4;
  logic        in_v1 = 1'b0, out_rdy1 = 1'b0;
  logic        in_rdy1, acc_clr1, out_v1;
  logic [15:0] in_acc1 = '0, out_dat1;

  mvu_out_stage #(.PE(2), .TDstI(8), .SF(4), .DEPTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_v(in_v4), .in_rdy(in_rdy4), .in_acc(in_acc4),
    .acc_clr(acc_clr4), .out_v(out_v4), .out_rdy(out_rdy4), .out_dat(out_dat4));

  mvu_out_stage #(.PE(2), .TDstI(8), .SF(1), .DEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_v(in_v1), .in_rdy(in_rdy1), .in_acc(in_acc1),
    .acc_clr(acc_clr1), .out_v(out_v1), .out_rdy(out_rdy1), .out_dat(out_dat1));

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] q4[$], q1[$];
  int          m_fcnt4 = 0;
  logic        m_pend4 = 1'b0, m_pend1 = 1'b0;
  logic        stall4 = 1'b0, stall1 = 1'b0;
  logic [15:0] prev4, prev1;
  int          pops4 = 0, pops1 = 0, pushes4 = 0, pushes1 = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Fold model + output monitor for the SF=4 instance.
  always @(negedge clk) begin
    if (!rst_n) begin
      q4.delete();
      m_fcnt4 = 0;
      m_pend4 = 1'b0;
      stall4  = 1'b0;
    end else begin
      if (stall4) begin
        check("stall_v4", out_v4, 1);
        check("stall_dat4", out_dat4, prev4);
      end
      if (out_v4 && out_rdy4) begin
        pops4++;
        if (q4.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pop4_unexpected: got %0h expected no vector", out_dat4);
        end else begin
          logic [15:0] e;
          e = q4.pop_front();
          check("dat4", out_dat4, e);
        end
      end
      stall4 = out_v4 && !out_rdy4;
      prev4  = out_dat4;
      check("clr4", acc_clr4, m_pend4);
      if (m_pend4) begin q4.push_back(in_acc4); pushes4++; end
      assert (!(in_v4 && !in_rdy4)) else $error("protocol violation on dut4");
      m_pend4 = in_v4 && (m_fcnt4 == 3);
      if (in_v4) m_fcnt4 = (m_fcnt4 == 3) ? 0 : m_fcnt4 + 1;
    end
  end

  // Fold model + output monitor for the SF=1 instance (every beat is last).
  always @(negedge clk) begin
    if (!rst_n) begin
      q1.delete();
      m_pend1 = 1'b0;
      stall1  = 1'b0;
    end else begin
      if (stall1) begin
        check("stall_v1", out_v1, 1);
        check("stall_dat1", out_dat1, prev1);
      end
      if (out_v1 && out_rdy1) begin
        pops1++;
        if (q1.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL pop1_unexpected: got %0h expected no vector", out_dat1);
        end else begin
          logic [15:0] e;
          e = q1.pop_front();
          check("dat1", out_dat1, e);
        end
      end
      stall1 = out_v1 && !out_rdy1;
      prev1  = out_dat1;
      check("clr1", acc_clr1, m_pend1);
      if (m_pend1) begin q1.push_back(in_acc1); pushes1++; end
      assert (!(in_v1 && !in_rdy1)) else $error("protocol violation on dut1");
      m_pend1 = in_v1;
    end
  end

  task automatic drain(input int sel);
    int k = 0;
    if (sel == 4) begin
      in_v4 = 1'b0; out_rdy4 = 1'b1;
      while ((q4.size() != 0 || out_v4) && k < 60) begin tick(); k++; end
      check("drain4_left", q4.size(), 0);
      check("drain4_out_v", out_v4, 0);
    end else begin
      in_v1 = 1'b0; out_rdy1 = 1'b1;
      while ((q1.size() != 0 || out_v1) && k < 60) begin tick(); k++; end
      check("drain1_left", q1.size(), 0);
      check("drain1_out_v", out_v1, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) tick();
    check("rst_out_v4", out_v4, 0);
    check("rst_clr4", acc_clr4, 0);
    check("rst_in_rdy4", in_rdy4, 1);
    check("rst_out_v1", out_v1, 0);
    check("rst_in_rdy1", in_rdy1, 1);
    rst_n = 1'b1;
    tick();

    // T1: one fold of 4 beats, capture value 0x1234.
    out_rdy4 = 1'b1;
    for (int i = 0; i < 4; i++) begin in_v4 = 1'b1; in_acc4 = 16'h00a0 + 16'(i); tick(); end
    check("t1_clr_hi", acc_clr4, 1);
    check("t1_out_v_lo", out_v4, 0);
    in_v4 = 1'b0; in_acc4 = 16'h1234;
    tick();
    check("t1_clr_lo", acc_clr4, 0);
    check("t1_out_v_hi", out_v4, 1);
    check("t1_out_dat", out_dat4, 16'h1234);
    in_acc4 = 16'h0;
    tick();
    check("t1_out_v_drop", out_v4, 0);

    // T2: SF=1 continuous beats, incrementing data, back-to-back captures.
    out_rdy1 = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_v1 = in_rdy1; in_acc1 = 16'h0100 + 16'(i);
      tick();
      check("t2_clr", acc_clr1, 1);
      if (i >= 1) check("t2_no_bubble", out_v1, 1);
    end
    in_v1 = 1'b0; in_acc1 = 16'h0114;
    tick(); tick(); tick();
    check("t2_idle", out_v1, 0);

    // T3: SF=1 with downstream stalled: exactly 4 entries, then drain.
    out_rdy1 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      in_v1 = in_rdy1; in_acc1 = 16'h0200 + 16'(i);
      tick();
    end
    in_v1 = 1'b0;
    check("t3_in_rdy_lo", in_rdy1, 0);
    check("t3_count_full", u_dut1.w_count, 4);
    check("t3_held", pushes1 - pops1, 4);
    out_rdy1 = 1'b1;
    tick();
    check("t3_in_rdy_back", in_rdy1, 1);
    tick(); tick(); tick();
    check("t3_empty", out_v1, 0);

    // T4: SF=4, out_rdy toggling, 64 random vectors through the scoreboard.
    base = pushes4;
    for (int k = 0; k < 2000 && (pushes4 - base) < 64; k++) begin
      out_rdy4 = ~out_rdy4;
      in_v4 = in_rdy4;
      in_acc4 = 16'($urandom);
      tick();
    end
    check("t4_vectors", (pushes4 - base) >= 64, 1);
    drain(4);
    check("t4_no_loss", pushes4, pops4);

    // T5: reset mid-fold with 2 vectors queued discards everything.
    out_rdy4 = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_v4 = (i < 10) && in_rdy4; in_acc4 = 16'h5000 + 16'(i);
      tick();
    end
    in_v4 = 1'b0;
    check("t5_queued", u_dut4.w_count, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_out_v", out_v4, 0);
    check("t5_async_in_rdy", in_rdy4, 1);
    check("t5_async_clr", acc_clr4, 0);
    tick(); tick();
    rst_n = 1'b1;
    pops4 = 0;
    out_rdy4 = 1'b1;
    for (int i = 0; i < 4; i++) begin in_v4 = in_rdy4; in_acc4 = 16'h6000 + 16'(i); tick(); end
    in_v4 = 1'b0; in_acc4 = 16'hbeef;
    tick(); tick(); tick(); tick();
    check("t5_one_vector", pops4, 1);
    check("t5_idle", out_v4, 0);

    // T6: full FIFO, simultaneous pop and capture, then many pointer wraps.
    out_rdy1 = 1'b0;
    for (int i = 0; i < 6; i++) begin in_v1 = in_rdy1; in_acc1 = 16'h0300 + 16'(i); tick(); end
    in_v1 = 1'b0; out_rdy1 = 1'b1;
    tick();
    check("t6_count3", u_dut1.w_count, 3);
    out_rdy1 = 1'b0; in_v1 = in_rdy1; in_acc1 = 16'h0310;
    tick();
    check("t6_in_rdy_lo", in_rdy1, 0);
    in_v1 = 1'b0; out_rdy1 = 1'b1; in_acc1 = 16'h0311;
    tick();
    check("t6_pop_push_count", u_dut1.w_count, 3);
    check("t6_in_rdy_hi", in_rdy1, 1);
    base = pushes1;
    for (int i = 0; i < 80; i++) begin
      in_v1 = in_rdy1; in_acc1 = 16'h7000 + 16'(i);
      tick();
    end
    check("t6_wraps", (pushes1 - base) >= 40, 1);
    drain(1);
    check("t6_no_loss", pushes1, pops1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
